// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key-number mapping and frame-FSM state type
// for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [8:0] KEY_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_RIGHT = 9'h174;

  localparam logic [3:0] KN_LEFT    = 4'd2;
  localparam logic [3:0] KN_RIGHT   = 4'd3;
  localparam logic [3:0] KN_INVALID = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  function automatic logic [3:0] key_num_of(input logic [8:0] code);
    logic [3:0] kn;
    case (code)
      KEY_LEFT:  kn = KN_LEFT;
      KEY_RIGHT: kn = KN_RIGHT;
      default:   kn = KN_INVALID;
    endcase
    return kn;
  endfunction

  // Eight data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: input synchronizers, clock glitch filter, 11-bit frame
// FSM with idle timeout. Emits one-cycle byte_valid / byte_err strobes.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_r, data_sync_r;
  logic [FW-1:0] flt_cnt_r;
  logic          clk_flt_r, clk_flt_d_r;
  frame_state_e  state_r, state_n;
  logic [2:0]    bit_cnt_r, bit_cnt_n;
  logic [7:0]    shift_r, shift_n;
  logic          par_r, par_n;
  logic [TW-1:0] to_cnt_r, to_cnt_n;
  logic [7:0]    rx_byte_r, rx_byte_n;
  logic          byte_valid_r, byte_valid_n;
  logic          byte_err_r, byte_err_n;
  logic          fall_s, data_s, timeout_s;

  assign data_s    = data_sync_r[1];
  assign fall_s    = clk_flt_d_r & ~clk_flt_r;
  assign timeout_s = (to_cnt_r == TO_LAST);

  // Synchronizers and a level filter that needs FILTER_LEN agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      flt_cnt_r   <= '0;
      clk_flt_r   <= 1'b1;
      clk_flt_d_r <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_flt_d_r <= clk_flt_r;
      if (clk_sync_r[1] == clk_flt_r) begin
        flt_cnt_r <= '0;
      end else if (flt_cnt_r == FLT_LAST) begin
        clk_flt_r <= clk_sync_r[1];
        flt_cnt_r <= '0;
      end else begin
        flt_cnt_r <= flt_cnt_r + 1'b1;
      end
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      to_cnt_r     <= '0;
      rx_byte_r    <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_err_r   <= 1'b0;
    end else begin
      state_r      <= state_n;
      bit_cnt_r    <= bit_cnt_n;
      shift_r      <= shift_n;
      par_r        <= par_n;
      to_cnt_r     <= to_cnt_n;
      rx_byte_r    <= rx_byte_n;
      byte_valid_r <= byte_valid_n;
      byte_err_r   <= byte_err_n;
    end
  end

  // Next-state logic; each non-idle state falls back to IDLE on timeout.
  always_comb begin
    state_n      = state_r;
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    par_n        = par_r;
    rx_byte_n    = rx_byte_r;
    byte_valid_n = 1'b0;
    byte_err_n   = 1'b0;
    if ((state_r == ST_IDLE) || fall_s) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt_r + 1'b1;
    end
    case (state_r)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          state_n   = ST_DATA;
          bit_cnt_n = 3'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_n   = {data_s, shift_r[7:1]};
          bit_cnt_n = bit_cnt_r + 3'd1;
          state_n   = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
        end else if (timeout_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          par_n   = data_s;
          state_n = ST_STOP;
        end else if (timeout_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_n = ST_IDLE;
          if (odd_parity_ok({shift_r, par_r}) && data_s) begin
            byte_valid_n = 1'b1;
            rx_byte_n    = shift_r;
          end else begin
            byte_err_n = 1'b1;
          end
        end else if (timeout_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign rx_byte    = rx_byte_r;
  assign byte_valid = byte_valid_r;
  assign byte_err   = byte_err_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: tracks E0/F0 prefixes, maintains the 512-bit
// key-state bitmap and reports the most recent make/break event.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic         clk_100MHz,
  input  logic         rst_n,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic [3:0]   key_num
);

  logic [7:0]   rx_byte_s;
  logic         byte_valid_s, byte_err_s;
  logic [8:0]   code_s;
  logic         ext_r, brk_r;
  logic [511:0] key_down_r;
  logic [8:0]   last_change_r;
  logic         been_ready_r;
  logic [3:0]   key_num_r;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk_100MHz),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte_s),
    .byte_valid(byte_valid_s),
    .byte_err  (byte_err_s)
  );

  assign code_s = {ext_r, rx_byte_s};

  // Prefix flags, key bitmap and event outputs, all updated on one edge.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ext_r         <= 1'b0;
      brk_r         <= 1'b0;
      key_down_r    <= '0;
      last_change_r <= 9'h000;
      been_ready_r  <= 1'b0;
      key_num_r     <= KN_INVALID;
    end else begin
      been_ready_r <= 1'b0;
      if (byte_err_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else if (byte_valid_s) begin
        case (rx_byte_s)
          SC_EXT:   ext_r <= 1'b1;
          SC_BRK:   brk_r <= 1'b1;
          SC_PAUSE: begin
          end
          default: begin
            key_down_r[code_s] <= ~brk_r;
            last_change_r      <= code_s;
            key_num_r          <= key_num_of(code_s);
            been_ready_r       <= 1'b1;
            ext_r              <= 1'b0;
            brk_r              <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_down    = key_down_r;
  assign last_change = last_change_r;
  assign been_ready  = been_ready_r;
  assign key_num     = key_num_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of frames plus hand-written
// timeout, glitch and mid-frame reset sequences, checked through a scoreboard.
module tb_ps2_key_decoder;

  localparam int FLT  = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic [3:0]   key_num;

  ps2_key_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .key_num    (key_num)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] code;
    logic [3:0] kn;
    logic       kd;
    longint     at;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         pulse;
    logic [8:0] code;
    logic [3:0] kn;
    logic       kd;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  cur;
  vec_t tbl[17];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   err_pulses = 0;
  int   p0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame; optionally pushes the expected event at the stop-bit fall.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit glitch,
                            input bit push, input logic [8:0] code, input logic [3:0] kn, input logic kd);
    logic [10:0] fr;
    ev_t e;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && (i == 2 || i == 6)) begin
        wait_cycles(4);
        ps2_clk = 1'b0;
        wait_cycles(FLT - 1);
        ps2_clk = 1'b1;
        wait_cycles(HALF - 4 - (FLT - 1));
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10 && push) begin
        e.code = code; e.kn = kn; e.kd = kd; e.at = cyc + FLT + 4;
        exp_q.push_back(e);
      end
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  // Scoreboard: every been_ready pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && dut.u_rx.byte_err) err_pulses++;
    if (rst_n && been_ready) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("pulse_expected", 512'(exp_q.size() != 0), 512'd1);
      end else begin
        cur = exp_q.pop_front();
        check("last_change", 512'(last_change), 512'(cur.code));
        check("key_num", 512'(key_num), 512'(cur.kn));
        check("latency_cycle", 512'(cyc), 512'(cur.at));
        check("key_down_bit", 512'(key_down[cur.code]), 512'(cur.kd));
      end
    end
  end

  initial begin
    tbl[0]  = '{8'h6B, 1'b0, 1'b1, 9'h06B, 4'd4, 1'b1};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[2]  = '{8'h6B, 1'b0, 1'b1, 9'h06B, 4'd4, 1'b0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[4]  = '{8'h74, 1'b0, 1'b1, 9'h174, 4'd3, 1'b1};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[7]  = '{8'h74, 1'b0, 1'b1, 9'h174, 4'd3, 1'b0};
    tbl[8]  = '{8'hE0, 1'b1, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[9]  = '{8'h6B, 1'b0, 1'b1, 9'h06B, 4'd4, 1'b1};
    tbl[10] = '{8'hE0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[11] = '{8'h6B, 1'b0, 1'b1, 9'h16B, 4'd2, 1'b1};
    tbl[12] = '{8'hE0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[13] = '{8'hE1, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[14] = '{8'h1C, 1'b0, 1'b1, 9'h11C, 4'd4, 1'b1};
    tbl[15] = '{8'hF0, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0};
    tbl[16] = '{8'h6B, 1'b0, 1'b1, 9'h06B, 4'd4, 1'b0};

    wait_cycles(3);
    check("rst_key_down", key_down, 512'd0);
    check("rst_last_change", 512'(last_change), 512'd0);
    check("rst_been_ready", 512'(been_ready), 512'd0);
    check("rst_key_num", 512'(key_num), 512'd4);
    rst_n = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 17; i++) begin
      send_frame(tbl[i].b, tbl[i].bad, 11, 1'b0, tbl[i].pulse, tbl[i].code, tbl[i].kn, tbl[i].kd);
    end
    check("byte_err_count", 512'(err_pulses), 512'd1);
    check("bit_16B_kept", 512'(key_down[9'h16B]), 512'd1);
    check("bit_06B_clear", 512'(key_down[9'h06B]), 512'd0);
    check("bit_11C_kept", 512'(key_down[9'h11C]), 512'd1);
    check("bit_174_clear", 512'(key_down[9'h174]), 512'd0);

    p0 = pulses;
    send_frame(8'h1C, 1'b0, 5, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0);
    wait_cycles(TO + 10);
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b1, 9'h01C, 4'd4, 1'b1);
    check("timeout_one_pulse", 512'(pulses - p0), 512'd1);

    send_frame(8'h6B, 1'b0, 11, 1'b1, 1'b1, 9'h06B, 4'd4, 1'b1);

    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'hE0, 1'b0, 11, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0);
      send_frame(8'h6B, 1'b0, 11, 1'b0, 1'b1, 9'h16B, 4'd2, 1'b1);
    end
    check("typematic_pulses", 512'(pulses - p0), 512'd3);
    send_frame(8'hE0, 1'b0, 5, 1'b0, 1'b0, 9'h000, 4'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_key_down", key_down, 512'd0);
    check("mid_rst_last_change", 512'(last_change), 512'd0);
    check("mid_rst_been_ready", 512'(been_ready), 512'd0);
    check("mid_rst_key_num", 512'(key_num), 512'd4);
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(10);
    send_frame(8'h74, 1'b0, 11, 1'b0, 1'b1, 9'h074, 4'd4, 1'b1);

    wait_cycles(50);
    check("scoreboard_drained", 512'(exp_q.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard clock/data lines, assembles and checks 11-bit frames, and decodes set-2 scan codes (including the 0xE0 extended and 0xF0 break prefixes) into a 512-bit key-state bitmap. It also reports the most recent key event. It is the producer of the `key_down` / `last_change` / `been_ready` / `key_num` bundle consumed by the game's sprite and address-generation logic. It sits between the board's PS/2 pins and the game core, in the 100 MHz domain.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized `ps2_clk` samples needed to accept a level change.
- `TIMEOUT_CYC`, 100000: idle cycles mid-frame before the frame is abandoned (1 ms at 100 MHz).
- `clk_100MHz` input 1: sole clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw keyboard clock, asynchronous.
- `ps2_data` input 1: raw keyboard data, asynchronous.
- `key_down` output 512: bit `n` = 1 while key code `n` is held.
- `last_change` output 9: code of the most recent make/break, `{ext, byte}`.
- `been_ready` output 1: one-cycle pulse per decoded make or break event.
- `key_num` output 4: 2 = left (9'h16B), 3 = right (9'h174), 4 = invalid (any other `last_change`).

## Operation
- Reset values:
  - `key_down` = 0.
  - `last_change` = 0.
  - `been_ready` = 0.
  - `key_num` = 4.
  - Prefix flags `ext` and `brk` = 0.
  - Frame FSM in IDLE.
- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. The filtered clock changes level only after `FILTER_LEN` consecutive equal synchronized samples. `ps2_data` is sampled on each filtered falling edge.
- Frame FSM states: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: a falling edge with data 0 (start bit) → DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 bits shifted in, LSB first, then → PARITY.
  - PARITY: sample the bit; → STOP.
  - STOP: the byte is valid if the 8 data bits plus the parity bit contain an odd number of ones and the stop bit is 1. Otherwise raise `byte_err`. Either way → IDLE.
  - Timeout: in any non-IDLE state, `TIMEOUT_CYC` cycles without a filtered falling edge → IDLE. The partial byte is discarded with no error and no output change.
- Decoder, per valid byte:
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - 0xE1: ignored; flags unchanged.
  - Any other byte `b`: code = `{ext, b}`. Then `key_down[code]` ← `~brk`, `last_change` ← code, `key_num` ← mapping of code, `been_ready` ← 1 for one cycle, and `ext`, `brk` ← 0.
- `byte_err` clears `ext` and `brk`. `key_down` and `last_change` are unchanged.
- Typematic repeats, i.e. repeated makes of a held key, each produce a `been_ready` pulse. The `key_down` bit stays 1.
- A break for a key not marked down still pulses `been_ready` and writes 0.
- Other bits of `key_down` are never disturbed by an event.

## Timing
- `key_down`, `last_change`, `key_num` and `been_ready` all update on the same clock edge.
- Latency: `been_ready` asserts exactly `FILTER_LEN` + 4 cycles after `ps2_clk` falls for the stop bit. This assumes stable lines and decomposes as:
  - 2 cycles of synchronizer.
  - `FILTER_LEN` cycles of filter.
  - 1 cycle of edge sample / STOP check.
  - 1 cycle of decoder register.
- Maximum event rate is one per frame, well under one per cycle, so no buffering is needed. Consecutive `been_ready` pulses are always separated by ≥ 1 low cycle.
- `rst_n` asserted mid-frame or mid-prefix: everything returns to its reset value immediately. The first complete frame after deassertion is decoded normally.

## Structure
- Package `ps2_pkg`:
  - `SC_EXT` = 8'hE0, `SC_BRK` = 8'hF0, `SC_PAUSE` = 8'hE1.
  - `KEY_LEFT` = 9'h16B, `KEY_RIGHT` = 9'h174.
  - `KN_LEFT` = 2, `KN_RIGHT` = 3, `KN_INVALID` = 4.
  - Frame-FSM state enum.
- Sub-module `ps2_frame_rx`: synchronizers, glitch filter, frame FSM and timeout. Outputs `byte[7:0]`, a one-cycle `byte_valid` and a one-cycle `byte_err`.
- The top level holds the prefix flags, the `key_down` bitmap and the output registers.

## Test plan
- Frames 6B, F0 6B with `FILTER_LEN` = 8:
  - After 6B: `key_down[9'h06B]` = 1, `last_change` = 9'h06B, `key_num` = 4, one `been_ready` pulse exactly 12 cycles after the stop-bit falling edge.
  - After F0 6B: bit 06B = 0, second pulse.
- Frames E0 74, then E0 F0 74:
  - After E0 74: `key_down[9'h174]` = 1, `key_num` = 3.
  - After E0 F0 74: bit clears, `last_change` = 9'h174, exactly two pulses total.
- Frame E0 with a corrupted parity bit, then frame 6B: `byte_err` fires, `ext` is cleared, and 6B decodes as 9'h06B (not 9'h16B).
- Start, 4 data bits, then line idle for `TIMEOUT_CYC` + 10 cycles, then full frame 1C: the partial frame is dropped with no pulse; `last_change` = 9'h01C.
- Glitch: `ps2_clk` low pulses of `FILTER_LEN` − 1 cycles injected mid-frame; frame 6B still decodes correctly.
- Hold E0 6B down (3 repeated makes), then assert `rst_n` = 0 in the middle of the 4th frame: 3 pulses are seen, then all outputs go to reset values (`key_num` = 4). A following frame 74 decodes to 9'h074.
